// File: rtl/adc_pipe_pkg.sv
// Shared definitions for the 1.5-bit pipelined ADC encoder: stage decision
// codes, the decoded level type and the one-hot decision decoder.
package adc_pipe_pkg;

  localparam int CODE_W = 3;

  localparam logic [CODE_W-1:0] CODE_HI  = 3'b100;
  localparam logic [CODE_W-1:0] CODE_MID = 3'b010;
  localparam logic [CODE_W-1:0] CODE_LO  = 3'b001;

  typedef logic [1:0] level_t;

  typedef struct packed {
    logic   invalid;
    level_t k;
  } dec_t;

  // Non-one-hot decisions fall back to mid level, which keeps the error
  // bounded by the redundancy of the neighbouring stage.
  function automatic dec_t decode_code(input logic [CODE_W-1:0] code);
    dec_t r;
    r.invalid = 1'b0;
    r.k       = 2'd1;
    case (code)
      CODE_HI:  r.k = 2'd2;
      CODE_MID: r.k = 2'd1;
      CODE_LO:  r.k = 2'd0;
      default: begin
        r.invalid = 1'b1;
        r.k       = 2'd1;
      end
    endcase
    return r;
  endfunction

endpackage

// File: rtl/adc_pipe_code_dec.sv
// Combinational one-hot stage decision decoder: yields level k and an
// invalid-code indication.
module adc_pipe_code_dec
  import adc_pipe_pkg::*;
(
  input  logic [CODE_W-1:0] code,
  output level_t            k,
  output logic              invalid
);

  assign {invalid, k} = decode_code(code);

endmodule

// File: rtl/adc_pipe_encoder.sv
// Digital correction for a 3-stage 1.5-bit pipelined ADC: aligns the three
// stage decisions of one sample and overlap-adds them into a saturated code.
// Optional invalid-code flag output enabled by defining ADC_ENC_ERR_FLAG_EN.
module adc_pipe_encoder #(
  parameter int CODE_W = 3,
  parameter int DOUT_W = 3
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [CODE_W-1:0] d1_i,
  input  logic [CODE_W-1:0] d2_i,
  input  logic [CODE_W-1:0] d3_i,
  output logic [DOUT_W-1:0] d_o
`ifdef ADC_ENC_ERR_FLAG_EN
  ,
  output logic              err_o
`endif
);

  import adc_pipe_pkg::*;

  function automatic logic [DOUT_W-1:0] sat_code(input logic [3:0] s);
    if (int'(s) > (2**DOUT_W - 1))
      return '1;
    else
      return DOUT_W'(s);
  endfunction

  level_t     k1, k2, k3;
  logic [2:0] inv;

  adc_pipe_code_dec u_dec1 (.code(d1_i), .k(k1), .invalid(inv[0]));
  adc_pipe_code_dec u_dec2 (.code(d2_i), .k(k2), .invalid(inv[1]));
  adc_pipe_code_dec u_dec3 (.code(d3_i), .k(k3), .invalid(inv[2]));

  // Stage p0/p1: k1 waits two clocks, k2 one clock, so all three belong to one sample
  level_t k1_p0, k1_p1, k2_p0;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      k1_p0 <= '0;
      k1_p1 <= '0;
      k2_p0 <= '0;
    end else begin
      k1_p0 <= k1;
      k1_p1 <= k1_p0;
      k2_p0 <= k2;
    end
  end

  // Stage p2: overlap-add 2*k1 + k2 + k3 (0..8) and saturate into the output register
  logic [3:0] sum_p2;

  assign sum_p2 = {1'b0, k1_p1, 1'b0} + {2'b00, k2_p0} + {2'b00, k3};

  always_ff @(posedge clock_i) begin
    if (reset_i)
      d_o <= '0;
    else
      d_o <= sat_code(sum_p2);
  end

`ifdef ADC_ENC_ERR_FLAG_EN
  logic inv1_p0, inv1_p1, inv2_p0;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      inv1_p0 <= 1'b0;
      inv1_p1 <= 1'b0;
      inv2_p0 <= 1'b0;
      err_o   <= 1'b0;
    end else begin
      inv1_p0 <= inv[0];
      inv1_p1 <= inv1_p0;
      inv2_p0 <= inv[1];
      err_o   <= inv1_p1 | inv2_p0 | inv[2];
    end
  end
`else
  logic unused_inv;
  assign unused_inv = ^inv;
`endif

endmodule

// File: tb/tb_adc_pipe_encoder.sv
// Self-checking bench for adc_pipe_encoder: directed vector table, multi-cycle
// alignment/reset/invalid-code sequences and a 0..1 V behavioural sweep.
module tb_adc_pipe_encoder;

  logic       clk;
  logic       reset_i;
  logic [2:0] d1, d2, d3;
  logic [2:0] d_o;
`ifdef ADC_ENC_ERR_FLAG_EN
  logic       err_o;
`endif

  int errors = 0;
  int checks = 0;

  adc_pipe_encoder #(.CODE_W(3), .DOUT_W(3)) dut (
    .clock_i(clk),
    .reset_i(reset_i),
    .d1_i   (d1),
    .d2_i   (d2),
    .d3_i   (d3),
    .d_o    (d_o)
`ifdef ADC_ENC_ERR_FLAG_EN
    ,
    .err_o  (err_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0] d1;
    logic [2:0] d2;
    logic [2:0] d3;
    logic [2:0] exp_code;
    logic       exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
    d1 = a;
    d2 = b;
    d3 = c;
  endtask

  function automatic int kq(input int mv);
    if (mv > 750) return 2;
    if (mv > 250) return 1;
    return 0;
  endfunction

  function automatic logic [2:0] enc(input int k);
    if (k == 2) return 3'b100;
    if (k == 1) return 3'b010;
    return 3'b001;
  endfunction

  int k1a[1001];
  int k2a[1001];
  int k3a[1001];

  initial begin
    int r1, r2, ex;
    logic [2:0] prev;

    // Constant-stream vectors: steady state after three clocks.
    vecs[0]  = '{3'b010, 3'b010, 3'b010, 3'd4, 1'b0};
    vecs[1]  = '{3'b001, 3'b010, 3'b010, 3'd2, 1'b0};
    vecs[2]  = '{3'b100, 3'b100, 3'b100, 3'd7, 1'b0};
    vecs[3]  = '{3'b100, 3'b001, 3'b010, 3'd5, 1'b0};
    vecs[4]  = '{3'b001, 3'b001, 3'b001, 3'd0, 1'b0};
    vecs[5]  = '{3'b010, 3'b001, 3'b001, 3'd2, 1'b0};
    vecs[6]  = '{3'b001, 3'b100, 3'b001, 3'd2, 1'b0};
    vecs[7]  = '{3'b001, 3'b001, 3'b100, 3'd2, 1'b0};
    vecs[8]  = '{3'b100, 3'b010, 3'b001, 3'd5, 1'b0};
    vecs[9]  = '{3'b100, 3'b100, 3'b010, 3'd7, 1'b0};
    vecs[10] = '{3'b100, 3'b010, 3'b010, 3'd6, 1'b0};
    vecs[11] = '{3'b001, 3'b011, 3'b001, 3'd1, 1'b1};
    vecs[12] = '{3'b000, 3'b001, 3'b001, 3'd2, 1'b1};
    vecs[13] = '{3'b001, 3'b001, 3'b111, 3'd1, 1'b1};
    vecs[14] = '{3'b110, 3'b100, 3'b100, 3'd6, 1'b1};
    vecs[15] = '{3'b100, 3'b100, 3'b000, 3'd7, 1'b1};

    // Reset held two clocks with low inputs.
    reset_i = 1'b1;
    drive(3'b001, 3'b001, 3'b001);
    tick();
    check("reset_cyc1", 8'(d_o), 8'd0);
    tick();
    check("reset_cyc2", 8'(d_o), 8'd0);
`ifdef ADC_ENC_ERR_FLAG_EN
    check("reset_err", 8'(err_o), 8'd0);
`endif
    reset_i = 1'b0;
    tick();
    check("post_reset", 8'(d_o), 8'd0);

    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].d1, vecs[i].d2, vecs[i].d3);
      repeat (3) tick();
      check($sformatf("vec%0d_code", i), 8'(d_o), 8'(vecs[i].exp_code));
`ifdef ADC_ENC_ERR_FLAG_EN
      check($sformatf("vec%0d_err", i), 8'(err_o), 8'(vecs[i].exp_err));
`endif
    end

    // Latency: 001 stream, then one sample at 010 entering correctly staggered.
    drive(3'b001, 3'b001, 3'b001);
    repeat (3) tick();
    check("lat_base", 8'(d_o), 8'd0);
    drive(3'b010, 3'b001, 3'b001);
    tick();
    check("lat_t", 8'(d_o), 8'd0);
    drive(3'b010, 3'b010, 3'b001);
    tick();
    check("lat_t1", 8'(d_o), 8'd0);
    drive(3'b010, 3'b010, 3'b010);
    tick();
    check("lat_t2", 8'(d_o), 8'd4);
    tick();
    check("lat_t3", 8'(d_o), 8'd4);

    // Single invalid stage-2 decision inside a mid-level stream.
    d2 = 3'b011;
    tick();
    check("inv_e0", 8'(d_o), 8'd4);
`ifdef ADC_ENC_ERR_FLAG_EN
    check("inv_e0_err", 8'(err_o), 8'd0);
`endif
    d2 = 3'b010;
    tick();
    check("inv_e1", 8'(d_o), 8'd4);
`ifdef ADC_ENC_ERR_FLAG_EN
    check("inv_e1_err", 8'(err_o), 8'd1);
`endif
    tick();
    check("inv_e2", 8'(d_o), 8'd4);
`ifdef ADC_ENC_ERR_FLAG_EN
    check("inv_e2_err", 8'(err_o), 8'd0);
`endif

    // One-clock reset in a steady 010 stream, then history refills:
    // k3 only (1), k2+k3 (2), then full 2*k1+k2+k3 (4).
    reset_i = 1'b1;
    tick();
    check("midrst", 8'(d_o), 8'd0);
    reset_i = 1'b0;
    tick();
    check("recov1", 8'(d_o), 8'd1);
    tick();
    check("recov2", 8'(d_o), 8'd2);
    tick();
    check("recov3", 8'(d_o), 8'd4);

    // Behavioural sweep 0..1000 mV: comparators at 250/750 mV, residue 2V - k*500.
    for (int m = 0; m <= 1000; m++) begin
      k1a[m] = kq(m);
      r1 = 2 * m - 500 * k1a[m];
      k2a[m] = kq(r1);
      r2 = 2 * r1 - 500 * k2a[m];
      k3a[m] = kq(r2);
    end
    prev = 3'd0;
    for (int n = 0; n < 1003; n++) begin
      d1 = (n <= 1000) ? enc(k1a[n]) : 3'b001;
      d2 = (n >= 1 && n <= 1001) ? enc(k2a[n-1]) : 3'b001;
      d3 = (n >= 2) ? enc(k3a[n-2]) : 3'b001;
      tick();
      if (n >= 2) begin
        ex = 2 * k1a[n-2] + k2a[n-2] + k3a[n-2];
        if (ex > 7) ex = 7;
        check($sformatf("sweep_%0dmV", n - 2), 8'(d_o), 8'(ex));
        if (n > 2) begin
          checks++;
          if (d_o < prev) begin
            errors++;
            $display("FAIL sweep_mono_%0dmV: got %0d after %0d", n - 2, d_o, prev);
          end
        end
        prev = d_o;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
